// File: rtl/mdu_iterative.sv
// Fixed-latency multiply/divide unit holding HI/LO; MADD/MSUB family
// is built only when MDU_MADD_EN is defined.
module mdu_iterative #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    localparam logic [3:0] N_MUL = 4'(MULT_CYCLES);
    localparam logic [3:0] N_DIV = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        done_q, done_d;

    logic is_mul, is_div, is_mthi, is_mtlo, is_long;
`ifdef MDU_MADD_EN
    logic        is_acc;
    logic [63:0] acc;
`endif

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
`ifdef MDU_MADD_EN
        is_acc  = 1'b0;
`endif
        case (mdu_op)
            OP_MULT, OP_MULTU: is_mul  = 1'b1;
            OP_DIV, OP_DIVU:   is_div  = 1'b1;
            OP_MTHI:           is_mthi = 1'b1;
            OP_MTLO:           is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: is_acc  = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef MDU_MADD_EN
    assign is_long = is_mul | is_div | is_acc;
`else
    assign is_long = is_mul | is_div;
`endif

    // Odd opcodes of every arithmetic pair are the unsigned variant.
    logic        uns;
    logic [63:0] prod_s, prod_u, prod;
    assign uns    = mdu_op[0];
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod   = uns ? prod_u : prod_s;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    logic [31:0] abs_a, abs_b, mq, mr;
    logic [31:0] quo_s, rem_s, quo, rem;
    assign abs_a = a[31] ? -a : a;
    assign abs_b = b[31] ? -b : b;
    assign mq    = abs_a / abs_b;
    assign mr    = abs_a % abs_b;
    assign quo_s = (a[31] ^ b[31]) ? -mq : mq;
    assign rem_s = a[31] ? -mr : mr;
    assign quo   = uns ? a / b : quo_s;
    assign rem   = uns ? a % b : rem_s;

    logic [63:0] res;
`ifdef MDU_MADD_EN
    assign acc = {hi_q, lo_q};
`endif

    always_comb begin
        res = prod;
        if (is_div) begin
            res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
        end
`ifdef MDU_MADD_EN
        else if (is_acc) begin
            res = mdu_op[3] ? acc - prod : acc + prod;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mthi) begin
                        hi_d = a;
                    end else if (is_mtlo) begin
                        lo_d = a;
                    end else if (is_long) begin
                        pend_hi_d = res[63:32];
                        pend_lo_d = res[31:0];
                        cnt_d     = is_div ? N_DIV : N_MUL;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected {hi,lo} queued on issue,
// compared on each done pulse.
module tb_mdu_iterative;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sbq[$];

    mdu_iterative dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            chk("sb_empty_at_done", 64'(sbq.size() == 0), 64'd0);
            if (sbq.size() != 0) chk("result", {hi, lo}, sbq.pop_front());
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] oa,
                         input logic [31:0] ob);
        @(posedge clk); #1;
        start = 1'b1; mdu_op = op; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] oa, input logic [31:0] ob,
                          input logic [63:0] exp, input int n, input int inj);
        int nb, d0;
        sbq.push_back(exp);
        d0 = done_cnt;
        nb = 0;
        issue(op, oa, ob);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (i == inj) begin
                start = 1'b1; mdu_op = OP_DIVU; a = 32'd100; b = 32'd7;
            end
            if (busy) begin
                nb++;
                chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
            end else break;
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(n));
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_sb_drained"}, 64'(sbq.size()), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        int d0;
        d0 = done_cnt;
        issue(op, v, 32'd0);
        if (op == OP_MTHI) m_hi = v; else m_lo = v;
        @(negedge clk);
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_no_done", 64'(done_cnt - d0), 64'd0);
    endtask

    task automatic ign(input string tag, input logic [3:0] op);
        int d0;
        d0 = done_cnt;
        issue(op, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 64'(busy), 64'd0);
        end
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        chk({tag, "_no_done"}, 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int sa, sb, d0;
        longint sp;
        longint unsigned up;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_op("mult", OP_MULT, -32'sd3, 32'd7,
               {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 5, -1);
        run_op("multu", OP_MULTU, -32'sd3, 32'd7,
               {32'h0000_0006, 32'hFFFF_FFEB}, 5, -1);
        run_op("div", OP_DIV, -32'sd7, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, -1);
        run_op("div0", OP_DIV, 32'd5, 32'd0,
               {32'h0000_0005, 32'hFFFF_FFFF}, 10, -1);
        run_op("divu0", OP_DIVU, 32'hDEAD_BEEF, 32'd0,
               {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 10, -1);
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'h0000_0000, 32'h8000_0000}, 10, -1);
        run_op("divu", OP_DIVU, 32'd100, 32'd7,
               {32'd2, 32'd14}, 10, -1);

        mt(OP_MTHI, 32'h1234_5678);
        mt(OP_MTLO, 32'hCAFE_F00D);

        run_op("mult_inj", OP_MULT, 32'd6, 32'd9, {32'd0, 32'd54}, 5, 1);
        run_op("commit_inj", OP_MULTU, 32'hFFFF_FFFF, 32'd2,
               {32'd1, 32'hFFFF_FFFE}, 5, 4);

        for (int k = 0; k < 3; k++) begin
            ra = $urandom; rb = $urandom;
            sa = ra; sb = rb;
            sp = longint'(sa) * longint'(sb);
            run_op("rnd_mult", OP_MULT, ra, rb, 64'(sp), 5, -1);
            up = 64'(ra) * 64'(rb);
            run_op("rnd_multu", OP_MULTU, ra, rb, 64'(up), 5, -1);
            rb = 32'($urandom_range(2, 100000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            sb = rb;
            run_op("rnd_div", OP_DIV, ra, rb,
                   {32'(sa % sb), 32'(sa / sb)}, 10, -1);
            rb = $urandom | 32'd1;
            run_op("rnd_divu", OP_DIVU, ra, rb,
                   {ra % rb, ra / rb}, 10, -1);
        end

        ign("illegal_op", 4'd12);

        sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF0});
        d0 = done_cnt;
        issue(OP_MULT, 32'hFFFF_FFFC, 32'd4);
        for (int i = 0; i < 3; i++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_idle", 64'(busy), 64'd0);
        end
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        mt(OP_MTHI, 32'd0);
        mt(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, {32'd1, 32'd0}, 5, -1);
`else
        ign("maddu_off", OP_MADDU);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
